// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite 2-master/1-slave interconnect.
//   wr_state_e : write path FSM encodings
//   rd_state_e : read path FSM encodings
//   RESP_*     : AXI response codes (passed through, never generated here)
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_rr_arbiter2.sv
// Two-requester round-robin arbiter with a held grant.
//   clk, rst_n : clock, async active-low reset
//   req        : request pair (bit N = master N)
//   take       : capture a new grant this cycle (ignored if no request)
//   rel        : transaction finished; priority passes to the other master
//   grant      : registered index of the granted master
module axi4_lite_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  input  logic       rel,
  output logic       grant
);

  logic prio;
  logic winner;

  // Priority holder wins if it asks; otherwise the other one must be asking.
  always_comb winner = req[prio] ? prio : ~prio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= 1'b0;
      prio  <= 1'b0;
    end else begin
      if (take && (|req)) grant <= winner;
      if (rel)            prio  <= ~grant;
    end
  end

endmodule

// File: rtl/axi4_lite_interconnect_m2s1.sv
// AXI4-Lite interconnect: masters m0/m1 share slave s0.
// Write and read paths arbitrate independently (round-robin) and stay
// locked to the granted master from address phase to response handshake.
//   iCLK, iRST          : clock, async active-low reset
//   mN_AW*/W*/B*        : write channels from/to master N
//   mN_AR*/R*           : read channels from/to master N
//   s0_*                : channels to/from the shared slave
module axi4_lite_interconnect_m2s1
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  // master 0
  input  logic                    m0_AWVALID,
  input  logic [ADDR_WIDTH-1:0]   m0_AWADDR,
  output logic                    m0_AWREADY,
  input  logic                    m0_WVALID,
  input  logic [DATA_WIDTH-1:0]   m0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] m0_WSTRB,
  output logic                    m0_WREADY,
  output logic                    m0_BVALID,
  output logic [1:0]              m0_BRESP,
  input  logic                    m0_BREADY,
  input  logic                    m0_ARVALID,
  input  logic [ADDR_WIDTH-1:0]   m0_ARADDR,
  output logic                    m0_ARREADY,
  output logic                    m0_RVALID,
  output logic [DATA_WIDTH-1:0]   m0_RDATA,
  output logic [1:0]              m0_RRESP,
  input  logic                    m0_RREADY,
  // master 1
  input  logic                    m1_AWVALID,
  input  logic [ADDR_WIDTH-1:0]   m1_AWADDR,
  output logic                    m1_AWREADY,
  input  logic                    m1_WVALID,
  input  logic [DATA_WIDTH-1:0]   m1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] m1_WSTRB,
  output logic                    m1_WREADY,
  output logic                    m1_BVALID,
  output logic [1:0]              m1_BRESP,
  input  logic                    m1_BREADY,
  input  logic                    m1_ARVALID,
  input  logic [ADDR_WIDTH-1:0]   m1_ARADDR,
  output logic                    m1_ARREADY,
  output logic                    m1_RVALID,
  output logic [DATA_WIDTH-1:0]   m1_RDATA,
  output logic [1:0]              m1_RRESP,
  input  logic                    m1_RREADY,
  // slave 0
  output logic                    s0_AWVALID,
  output logic [ADDR_WIDTH-1:0]   s0_AWADDR,
  input  logic                    s0_AWREADY,
  output logic                    s0_WVALID,
  output logic [DATA_WIDTH-1:0]   s0_WDATA,
  output logic [DATA_WIDTH/8-1:0] s0_WSTRB,
  input  logic                    s0_WREADY,
  input  logic                    s0_BVALID,
  input  logic [1:0]              s0_BRESP,
  output logic                    s0_BREADY,
  output logic                    s0_ARVALID,
  output logic [ADDR_WIDTH-1:0]   s0_ARADDR,
  input  logic                    s0_ARREADY,
  input  logic                    s0_RVALID,
  input  logic [DATA_WIDTH-1:0]   s0_RDATA,
  input  logic [1:0]              s0_RRESP,
  output logic                    s0_RREADY
);

  localparam int SW = DATA_WIDTH/8;

  // Master-side signals gathered into index-by-master arrays.
  logic [1:0]                 awvalid, wvalid, bready, arvalid, rready;
  logic [1:0][ADDR_WIDTH-1:0] awaddr, araddr;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0][SW-1:0]         wstrb;

  assign awvalid = {m1_AWVALID, m0_AWVALID};
  assign wvalid  = {m1_WVALID,  m0_WVALID};
  assign bready  = {m1_BREADY,  m0_BREADY};
  assign arvalid = {m1_ARVALID, m0_ARVALID};
  assign rready  = {m1_RREADY,  m0_RREADY};
  assign awaddr  = {m1_AWADDR,  m0_AWADDR};
  assign araddr  = {m1_ARADDR,  m0_ARADDR};
  assign wdata   = {m1_WDATA,   m0_WDATA};
  assign wstrb   = {m1_WSTRB,   m0_WSTRB};

  logic [1:0]                 m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0][1:0]            m_bresp, m_rresp;
  logic [1:0][DATA_WIDTH-1:0] m_rdata;

  assign {m1_AWREADY, m0_AWREADY} = m_awready;
  assign {m1_WREADY,  m0_WREADY}  = m_wready;
  assign {m1_BVALID,  m0_BVALID}  = m_bvalid;
  assign {m1_BRESP,   m0_BRESP}   = m_bresp;
  assign {m1_ARREADY, m0_ARREADY} = m_arready;
  assign {m1_RVALID,  m0_RVALID}  = m_rvalid;
  assign {m1_RDATA,   m0_RDATA}   = m_rdata;
  assign {m1_RRESP,   m0_RRESP}   = m_rresp;

  // ---------------- write path ----------------
  wr_state_e wr_state, wr_next;
  logic      aw_done, w_done, aw_done_d, w_done_d;
  logic      aw_hs, w_hs;
  logic      w_take, w_rel, wg;

  axi4_lite_rr_arbiter2 u_wr_arb (
    .clk   (iCLK),
    .rst_n (iRST),
    .req   (awvalid),
    .take  (w_take),
    .rel   (w_rel),
    .grant (wg)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_state <= W_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      aw_done  <= aw_done_d;
      w_done   <= w_done_d;
    end
  end

  always_comb begin
    wr_next    = wr_state;
    aw_done_d  = aw_done;
    w_done_d   = w_done;
    w_take     = 1'b0;
    w_rel      = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    s0_AWVALID = 1'b0;
    s0_AWADDR  = '0;
    s0_WVALID  = 1'b0;
    s0_WDATA   = '0;
    s0_WSTRB   = '0;
    s0_BREADY  = 1'b0;
    m_awready  = '0;
    m_wready   = '0;
    m_bvalid   = '0;
    m_bresp    = '0;
    case (wr_state)
      W_IDLE: begin
        if (|awvalid) begin
          w_take  = 1'b1;
          wr_next = W_ADDR;
        end
      end
      W_ADDR: begin
        // Each channel is masked once it has handshaken so s0 never sees
        // a duplicate address or data beat while the other one lags.
        s0_AWVALID    = awvalid[wg] & ~aw_done;
        s0_AWADDR     = awaddr[wg];
        s0_WVALID     = wvalid[wg] & ~w_done;
        s0_WDATA      = wdata[wg];
        s0_WSTRB      = wstrb[wg];
        m_awready[wg] = s0_AWREADY & ~aw_done;
        m_wready[wg]  = s0_WREADY & ~w_done;
        aw_hs         = awvalid[wg] & ~aw_done & s0_AWREADY;
        w_hs          = wvalid[wg] & ~w_done & s0_WREADY;
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          wr_next   = W_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done | aw_hs;
          w_done_d  = w_done | w_hs;
        end
      end
      W_RESP: begin
        m_bvalid[wg] = s0_BVALID;
        m_bresp[wg]  = s0_BRESP;
        s0_BREADY    = bready[wg];
        if (s0_BVALID && bready[wg]) begin
          wr_next = W_IDLE;
          w_rel   = 1'b1;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // ---------------- read path ----------------
  rd_state_e rd_state, rd_next;
  logic      r_take, r_rel, rg;

  axi4_lite_rr_arbiter2 u_rd_arb (
    .clk   (iCLK),
    .rst_n (iRST),
    .req   (arvalid),
    .take  (r_take),
    .rel   (r_rel),
    .grant (rg)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) rd_state <= R_IDLE;
    else       rd_state <= rd_next;
  end

  always_comb begin
    rd_next    = rd_state;
    r_take     = 1'b0;
    r_rel      = 1'b0;
    s0_ARVALID = 1'b0;
    s0_ARADDR  = '0;
    s0_RREADY  = 1'b0;
    m_arready  = '0;
    m_rvalid   = '0;
    m_rdata    = '0;
    m_rresp    = '0;
    case (rd_state)
      R_IDLE: begin
        if (|arvalid) begin
          r_take  = 1'b1;
          rd_next = R_ADDR;
        end
      end
      R_ADDR: begin
        s0_ARVALID    = arvalid[rg];
        s0_ARADDR     = araddr[rg];
        m_arready[rg] = s0_ARREADY;
        if (arvalid[rg] && s0_ARREADY) rd_next = R_DATA;
      end
      R_DATA: begin
        m_rvalid[rg] = s0_RVALID;
        m_rdata[rg]  = s0_RDATA;
        m_rresp[rg]  = s0_RRESP;
        s0_RREADY    = rready[rg];
        if (s0_RVALID && rready[rg]) begin
          rd_next = R_IDLE;
          r_rel   = 1'b1;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

endmodule
